// File: rtl/seg_pkg.sv
// Shared types and glyph codes for the 8-digit seven-segment scanner.
// Also used by whatever logic produces the digit codes.
package seg_pkg;

  localparam int DIG_W   = 5;
  localparam int NUM_DIG = 8;

  localparam logic [3:0] GL_H     = 4'hA;
  localparam logic [3:0] GL_E     = 4'hB;
  localparam logic [3:0] GL_L     = 4'hC;
  localparam logic [3:0] GL_O     = 4'hD;
  localparam logic [3:0] GL_MINUS = 4'hE;
  localparam logic [3:0] GL_BLANK = 4'hF;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef struct packed {
    logic       dp;
    logic [3:0] glyph;
  } dig_t;

endpackage

// File: rtl/seg_glyph.sv
// Glyph code to active-low segment pattern, seg[0]=a .. seg[6]=g.
// Purely combinational.
module seg_glyph
  import seg_pkg::*;
(
  input  logic [3:0] glyph,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (glyph)
      4'h0:     seg = 7'h40;
      4'h1:     seg = 7'h79;
      4'h2:     seg = 7'h24;
      4'h3:     seg = 7'h30;
      4'h4:     seg = 7'h19;
      4'h5:     seg = 7'h12;
      4'h6:     seg = 7'h02;
      4'h7:     seg = 7'h78;
      4'h8:     seg = 7'h00;
      4'h9:     seg = 7'h10;
      GL_H:     seg = 7'h09;
      GL_E:     seg = 7'h06;
      GL_L:     seg = 7'h47;
      GL_O:     seg = 7'h40;
      GL_MINUS: seg = 7'h3F;
      GL_BLANK: seg = SEG_OFF;
      default:  seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 8-digit seven-segment scanner with per-slot dead time
// and a frame-aligned snapshot of the digit codes.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned DEAD_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_DIG*DIG_W-1:0] dig,
  output logic [NUM_DIG-1:0]       an,
  output logic [6:0]               seg,
  output logic                     dp,
  output logic                     frame
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]            cnt;
  logic [2:0]               idx;
  dig_t [NUM_DIG-1:0]       snap;
  logic                     wrap;
  logic                     last;
  dig_t                     cur;
  logic [6:0]               glyph_seg;
  logic [NUM_DIG-1:0]       an_d;
  logic [6:0]               seg_d;
  logic                     dp_d;
  logic [NUM_DIG-1:0]       an_q;
  logic [6:0]               seg_q;
  logic                     dp_q;
  logic                     frame_q;

  assign wrap = (cnt == CW'(SCAN_DIV - 1));
  assign last = wrap && (idx == 3'd7);
  assign cur  = snap[idx];

  seg_glyph u_glyph (
    .glyph (cur.glyph),
    .seg   (glyph_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      snap    <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt     <= wrap ? '0 : cnt + 1'b1;
      frame_q <= last;
      if (wrap)
        idx <= idx + 3'd1;
      // dig is only sampled here, so a frame never mixes two codes
      if (last)
        snap <= dig;
    end
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (en && (cnt >= CW'(DEAD_CYC))) begin
      an_d  = ~(NUM_DIG'(1) << idx);
      seg_d = glyph_seg;
      dp_d  = ~cur.dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule
